i2s_rx: RTL

I2S receiver that deserialises a stereo I2S stream (sclk, ws, sd) in the system clock domain. It delivers one signed 24-bit left/right sample pair per frame with a single-cycle valid strobe. It sits directly upstream of the FIR filter stage: `left_sample` drives the filter's `input_sig`, and `sample_valid` marks the instant a fresh sample is available.

---
 rtl/audio_pkg.sv | 11 +
 rtl/i2s_sync_edge.sv | 26 ++
 rtl/i2s_rx.sv | 103 ++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared audio constants and the I2S receiver state encoding.
package audio_pkg;
    localparam int SAMPLE_WIDTH  = 24;
    localparam int I2S_SLOT_BITS = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_state_t;
endpackage

// File: rtl/i2s_sync_edge.sv
// Two-flop synchroniser followed by one output register.
// EDGE=1 gives a registered rising-edge pulse; EDGE=0 gives the level, delayed to the same depth.
module i2s_sync_edge #(
    parameter bit EDGE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic q
);
    logic [1:0] sync;
    logic       prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= 2'b00;
            prev <= 1'b0;
            q    <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            prev <= sync[1];
            // Both variants share depth so ws/sd line up with the sclk rise pulse
            q    <= EDGE ? (sync[1] & ~prev) : prev;
        end
    end
endmodule

// File: rtl/i2s_rx.sv
// Stereo I2S receiver: delivers left/right WIDTH-bit sample pairs with a one-cycle valid strobe.
// Optional slot-length checking is built when I2S_RX_FRAME_CHECK_EN is defined.
module i2s_rx
    import audio_pkg::*;
#(
    parameter int WIDTH     = SAMPLE_WIDTH,
    parameter int SLOT_BITS = I2S_SLOT_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i2s_sclk,
    input  logic             i2s_ws,
    input  logic             i2s_sd,
    output logic [WIDTH-1:0] left_sample,
    output logic [WIDTH-1:0] right_sample,
    output logic             sample_valid,
    output logic             frame_err
);
    localparam int IDX_W = $clog2(WIDTH);

    logic             sclk_rise;
    logic             ws_s;
    logic             sd_s;
    logic             ws_prev;
    logic             ws_edge;
    logic [5:0]       cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] word;
    logic [IDX_W-1:0] idx;
    i2s_state_t       state;

    i2s_sync_edge #(.EDGE(1'b1)) u_sclk (.clk(clk), .rst_n(rst_n), .din(i2s_sclk), .q(sclk_rise));
    i2s_sync_edge #(.EDGE(1'b0)) u_ws   (.clk(clk), .rst_n(rst_n), .din(i2s_ws),   .q(ws_s));
    i2s_sync_edge #(.EDGE(1'b0)) u_sd   (.clk(clk), .rst_n(rst_n), .din(i2s_sd),   .q(sd_s));

    // Bits land at their left-justified position, so short slots come out zero-filled
    // and anything past WIDTH bits is simply not written.
    always_comb begin
        word    = shreg;
        idx     = IDX_W'(WIDTH - 1 - int'(cnt));
        if (int'(cnt) < WIDTH)
            word[idx] = sd_s;
        ws_edge = sclk_rise && (ws_s != ws_prev);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            ws_prev      <= 1'b0;
            cnt          <= '0;
            shreg        <= '0;
            hold         <= '0;
            left_sample  <= '0;
            right_sample <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (sclk_rise) begin
                ws_prev <= ws_s;
                if (ws_edge) begin
                    shreg <= '0;
                    cnt   <= '0;
                end else begin
                    shreg <= word;
                    if (cnt != 6'd63)
                        cnt <= cnt + 6'd1;
                end
            end
            // The bit carried on the ws-change rise is the LSB of the closing slot
            if (ws_edge) begin
                case (state)
                    IDLE: if (!ws_s) state <= LEFT;
                    LEFT: begin
                        hold  <= word;
                        state <= RIGHT;
                    end
                    RIGHT: begin
                        left_sample  <= hold;
                        right_sample <= word;
                        sample_valid <= 1'b1;
                        state        <= LEFT;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef I2S_RX_FRAME_CHECK_EN
    logic [6:0] slot_len;
    assign slot_len = {1'b0, cnt} + 7'd1;

    always_ff @(posedge clk) begin
        if (!rst_n)
            frame_err <= 1'b0;
        else if (ws_edge && state != IDLE && slot_len != 7'(SLOT_BITS))
            frame_err <= 1'b1;
    end
`else
    assign frame_err = 1'b0;
`endif
endmodule
